// File: rtl/decode_stage.sv
// RV32I decode stage: decodes one {pc, inst} beat from fetch into a registered ID-stage record.
// The handshake is valid/ready on both sides, backed by a single-entry output register.
module decode_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  input  logic            in_error,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [3:0]      out_opclass,
  output logic [2:0]      out_funct3,
  output logic            out_alt,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [31:0]     out_imm,
  output logic            out_rd_we,
  output logic            out_rs1_used,
  output logic            out_rs2_used,
  output logic            out_illegal,
  output logic            out_fetch_error
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [3:0] ClsLui     = 4'd0;
  localparam logic [3:0] ClsAuipc   = 4'd1;
  localparam logic [3:0] ClsJal     = 4'd2;
  localparam logic [3:0] ClsJalr    = 4'd3;
  localparam logic [3:0] ClsBranch  = 4'd4;
  localparam logic [3:0] ClsLoad    = 4'd5;
  localparam logic [3:0] ClsStore   = 4'd6;
  localparam logic [3:0] ClsOpImm   = 4'd7;
  localparam logic [3:0] ClsOp      = 4'd8;
  localparam logic [3:0] ClsFence   = 4'd9;
  localparam logic [3:0] ClsSystem  = 4'd10;
  localparam logic [3:0] ClsInvalid = 4'd15;

  logic        accept;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic [3:0]  dec_cls;
  logic [31:0] dec_imm;
  logic        dec_alt, dec_we, dec_rs1, dec_rs2, dec_ill;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];

  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21],
                  1'b0};

  always_comb begin
    dec_cls = ClsInvalid;
    dec_imm = '0;
    dec_alt = 1'b0;
    dec_we  = 1'b0;
    dec_rs1 = 1'b0;
    dec_rs2 = 1'b0;
    dec_ill = 1'b0;
    case (opcode)
      OpLui: begin
        dec_cls = ClsLui;
        dec_imm = imm_u;
        dec_we  = 1'b1;
      end
      OpAuipc: begin
        dec_cls = ClsAuipc;
        dec_imm = imm_u;
        dec_we  = 1'b1;
      end
      OpJal: begin
        dec_cls = ClsJal;
        dec_imm = imm_j;
        dec_we  = 1'b1;
      end
      OpJalr: begin
        dec_cls = ClsJalr;
        dec_imm = imm_i;
        dec_we  = 1'b1;
        dec_rs1 = 1'b1;
        dec_ill = (funct3 != 3'b000);
      end
      OpBranch: begin
        dec_cls = ClsBranch;
        dec_imm = imm_b;
        dec_rs1 = 1'b1;
        dec_rs2 = 1'b1;
        dec_ill = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OpLoad: begin
        dec_cls = ClsLoad;
        dec_imm = imm_i;
        dec_we  = 1'b1;
        dec_rs1 = 1'b1;
        dec_ill = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OpStore: begin
        dec_cls = ClsStore;
        dec_imm = imm_s;
        dec_rs1 = 1'b1;
        dec_rs2 = 1'b1;
        dec_ill = (funct3 > 3'b010);
      end
      OpOpImm: begin
        dec_cls = ClsOpImm;
        dec_imm = imm_i;
        dec_we  = 1'b1;
        dec_rs1 = 1'b1;
        dec_alt = (funct3 == 3'b101) && in_inst[30];
        // Only the shift encodings constrain funct7.
        if (funct3 == 3'b001) begin
          dec_ill = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          dec_ill = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
        end
      end
      OpOp: begin
        dec_cls = ClsOp;
        dec_we  = 1'b1;
        dec_rs1 = 1'b1;
        dec_rs2 = 1'b1;
        dec_alt = in_inst[30];
        dec_ill = !((funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OpFence: begin
        dec_cls = ClsFence;
      end
      OpSystem: begin
        dec_cls = ClsSystem;
        dec_imm = imm_i;
      end
      default: begin
        dec_ill = 1'b1;
      end
    endcase

    // A fetch error outranks any decode result, including an illegal one.
    if (in_error || dec_ill) begin
      dec_cls = ClsInvalid;
      dec_imm = '0;
      dec_alt = 1'b0;
      dec_we  = 1'b0;
      dec_rs1 = 1'b0;
      dec_rs2 = 1'b0;
    end
    if (in_error) begin
      dec_ill = 1'b0;
    end
    if (in_inst[11:7] == 5'd0) begin
      dec_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid       <= 1'b0;
      out_pc          <= '0;
      out_opclass     <= '0;
      out_funct3      <= '0;
      out_alt         <= 1'b0;
      out_rd          <= '0;
      out_rs1         <= '0;
      out_rs2         <= '0;
      out_imm         <= '0;
      out_rd_we       <= 1'b0;
      out_rs1_used    <= 1'b0;
      out_rs2_used    <= 1'b0;
      out_illegal     <= 1'b0;
      out_fetch_error <= 1'b0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        out_pc          <= in_pc;
        out_opclass     <= dec_cls;
        out_funct3      <= funct3;
        out_alt         <= dec_alt;
        out_rd          <= in_inst[11:7];
        out_rs1         <= in_inst[19:15];
        out_rs2         <= in_inst[24:20];
        out_imm         <= dec_imm;
        out_rd_we       <= dec_we;
        out_rs1_used    <= dec_rs1;
        out_rs2_used    <= dec_rs2;
        out_illegal     <= dec_ill;
        out_fetch_error <= in_error;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a vector table, hand-written handshake sequences, and a random phase
// checked against a queue-based reference model of the stage.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_error, flush, out_valid, out_ready;
  logic [31:0] in_pc, in_inst, out_pc, out_imm;
  logic [3:0]  out_opclass;
  logic [2:0]  out_funct3;
  logic        out_alt, out_rd_we, out_rs1_used, out_rs2_used, out_illegal, out_fetch_error;
  logic [4:0]  out_rd, out_rs1, out_rs2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .in_error(in_error), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_opclass(out_opclass), .out_funct3(out_funct3),
    .out_alt(out_alt), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_rd_we(out_rd_we), .out_rs1_used(out_rs1_used), .out_rs2_used(out_rs2_used),
    .out_illegal(out_illegal), .out_fetch_error(out_fetch_error)
  );

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        we, r1u, r2u, ill, ferr;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    logic [3:0]  cls;
    logic [31:0] imm;
    logic        we, r1u, r2u, ill, alt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference decode built from the instruction-set rules: class/format lookup, set-membership
  // legality and immediates assembled arithmetically from the signed word.
  function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                      input logic err);
    exp_t e;
    logic [31:0] si, ss;
    logic [2:0]  f3;
    logic [6:0]  f7;
    byte         fmt;
    logic        legal, wr, r1, r2;
    int          cls;
    f3 = inst[14:12];
    f7 = inst[31:25];
    si = 32'($signed(inst) >>> 20);
    ss = (si & 32'hFFFF_FFE0) | {27'b0, inst[11:7]};
    legal = 1'b1;
    wr = 0; r1 = 0; r2 = 0; fmt = "N"; cls = 15;
    e.alt = 1'b0;
    case (inst[6:0])
      7'h37: begin cls = 0;  fmt = "U"; wr = 1; end
      7'h17: begin cls = 1;  fmt = "U"; wr = 1; end
      7'h6F: begin cls = 2;  fmt = "J"; wr = 1; end
      7'h67: begin cls = 3;  fmt = "I"; wr = 1; r1 = 1; legal = (f3 == 0); end
      7'h63: begin cls = 4;  fmt = "B"; r1 = 1; r2 = 1; legal = !(f3 inside {2, 3}); end
      7'h03: begin cls = 5;  fmt = "I"; wr = 1; r1 = 1; legal = !(f3 inside {3, 6, 7}); end
      7'h23: begin cls = 6;  fmt = "S"; r1 = 1; r2 = 1; legal = (f3 <= 2); end
      7'h13: begin
        cls = 7; fmt = "I"; wr = 1; r1 = 1;
        if (f3 == 1) legal = (f7 == 0);
        if (f3 == 5) begin
          legal = f7 inside {7'h00, 7'h20};
          e.alt = inst[30];
        end
      end
      7'h33: begin
        cls = 8; wr = 1; r1 = 1; r2 = 1; e.alt = inst[30];
        legal = (f7 == 0) || (f7 == 7'h20 && (f3 inside {0, 5}));
      end
      7'h0F: cls = 9;
      7'h73: begin cls = 10; fmt = "I"; end
      default: legal = 1'b0;
    endcase
    case (fmt)
      "I": e.imm = si;
      "S": e.imm = ss;
      "B": e.imm = (ss & 32'hFFFF_F7FE) | ({31'b0, inst[7]} << 11);
      "U": e.imm = inst & 32'hFFFF_F000;
      "J": e.imm = ((32'($signed(inst) >>> 11)) & 32'hFFF0_0000) | (inst & 32'h000F_F000) |
                   ((inst >> 9) & 32'h0000_0800) | ((inst >> 20) & 32'h0000_07FE);
      default: e.imm = 0;
    endcase
    e.pc = pc; e.f3 = f3; e.rd = inst[11:7]; e.rs1 = inst[19:15]; e.rs2 = inst[24:20];
    e.ferr = err;
    e.ill = !err && !legal;
    if (err || !legal) begin
      cls = 15; e.imm = 0; e.alt = 0; wr = 0; r1 = 0; r2 = 0;
    end
    e.cls = 4'(cls);
    e.we  = wr && (inst[11:7] != 0);
    e.r1u = r1;
    e.r2u = r2;
    return e;
  endfunction

  task automatic check_fields(input string tag, input exp_t e);
    chk({tag, ".pc"}, out_pc, e.pc);
    chk({tag, ".opclass"}, 32'(out_opclass), 32'(e.cls));
    chk({tag, ".funct3"}, 32'(out_funct3), 32'(e.f3));
    chk({tag, ".alt"}, 32'(out_alt), 32'(e.alt));
    chk({tag, ".rd"}, 32'(out_rd), 32'(e.rd));
    chk({tag, ".rs1"}, 32'(out_rs1), 32'(e.rs1));
    chk({tag, ".rs2"}, 32'(out_rs2), 32'(e.rs2));
    chk({tag, ".imm"}, out_imm, e.imm);
    chk({tag, ".rd_we"}, 32'(out_rd_we), 32'(e.we));
    chk({tag, ".rs1_used"}, 32'(out_rs1_used), 32'(e.r1u));
    chk({tag, ".rs2_used"}, 32'(out_rs2_used), 32'(e.r2u));
    chk({tag, ".illegal"}, 32'(out_illegal), 32'(e.ill));
    chk({tag, ".fetch_error"}, 32'(out_fetch_error), 32'(e.ferr));
  endtask

  initial begin
    vec_t        vecs[$];
    exp_t        q[$];
    exp_t        zero_e;
    logic [6:0]  ops[11];
    logic        acc;

    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    //               inst          err   cls    imm            we    r1u   r2u   ill   alt
    vecs.push_back('{32'h00500093, 1'b0, 4'd7,  32'h00000005, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'hFE208EE3, 1'b0, 4'd4,  32'hFFFFFFFC, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{32'h123452B7, 1'b0, 4'd0,  32'h12345000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h00000000, 1'b0, 4'd15, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{32'h40001013, 1'b0, 4'd15, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{32'h0000A067, 1'b0, 4'd15, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{32'h40208133, 1'b0, 4'd8,  32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{32'h4030D093, 1'b0, 4'd7,  32'h00000403, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{32'hFFC12083, 1'b0, 4'd5,  32'hFFFFFFFC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h00512423, 1'b0, 4'd6,  32'h00000008, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{32'h008000EF, 1'b0, 4'd2,  32'h00000008, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h00000013, 1'b0, 4'd7,  32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h00513423, 1'b0, 4'd15, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{32'h40209133, 1'b0, 4'd15, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{32'h0FF0000F, 1'b0, 4'd9,  32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h00000073, 1'b0, 4'd10, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h00100073, 1'b0, 4'd10, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h00500092, 1'b0, 4'd15, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{32'h00500093, 1'b1, 4'd15, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

    rst = 1; in_valid = 0; in_pc = 0; in_inst = 0; in_error = 0; flush = 0; out_ready = 1;
    tick();
    tick();
    chk("reset.out_valid", 32'(out_valid), 0);
    chk("reset.opclass", 32'(out_opclass), 0);
    chk("reset.in_ready", 32'(in_ready), 1);
    rst = 0;

    // addi x1,x0,5 at 0x100
    in_valid = 1; in_inst = 32'h00500093; in_pc = 32'h100;
    tick();
    in_valid = 0;
    chk("addi.out_valid", 32'(out_valid), 1);
    check_fields("addi", ref_decode(32'h00500093, 32'h100, 1'b0));
    chk("addi.rd_lit", 32'(out_rd), 1);
    chk("addi.imm_lit", out_imm, 5);
    tick();

    foreach (vecs[i]) begin
      in_valid = 1; in_inst = vecs[i].inst; in_error = vecs[i].err; in_pc = 32'(i * 4);
      tick();
      in_valid = 0; in_error = 0;
      chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 1);
      chk($sformatf("vec%0d.opclass", i), 32'(out_opclass), 32'(vecs[i].cls));
      chk($sformatf("vec%0d.imm", i), out_imm, vecs[i].imm);
      chk($sformatf("vec%0d.rd_we", i), 32'(out_rd_we), 32'(vecs[i].we));
      chk($sformatf("vec%0d.rs1_used", i), 32'(out_rs1_used), 32'(vecs[i].r1u));
      chk($sformatf("vec%0d.rs2_used", i), 32'(out_rs2_used), 32'(vecs[i].r2u));
      chk($sformatf("vec%0d.illegal", i), 32'(out_illegal), 32'(vecs[i].ill));
      chk($sformatf("vec%0d.alt", i), 32'(out_alt), 32'(vecs[i].alt));
      chk($sformatf("vec%0d.fetch_error", i), 32'(out_fetch_error), 32'(vecs[i].err));
      tick();
    end

    // Backpressure: addi held for three cycles while lui waits at the input.
    in_valid = 1; in_inst = 32'h00500093; in_pc = 32'h200;
    tick();
    in_inst = 32'h123452B7; in_pc = 32'h204; out_ready = 0;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp%0d.in_ready", c), 32'(in_ready), 0);
      chk($sformatf("bp%0d.out_valid", c), 32'(out_valid), 1);
      check_fields($sformatf("bp%0d", c), ref_decode(32'h00500093, 32'h200, 1'b0));
      tick();
    end
    out_ready = 1;
    #1;
    chk("bp_release.in_ready", 32'(in_ready), 1);
    chk("bp_release.pc", out_pc, 32'h200);
    tick();
    in_valid = 0;
    chk("bp_lui.out_valid", 32'(out_valid), 1);
    check_fields("bp_lui", ref_decode(32'h123452B7, 32'h204, 1'b0));
    tick();
    chk("bp_nodup.out_valid", 32'(out_valid), 0);

    // Flush with an incoming beat, then flush of a held beat.
    in_valid = 1; flush = 1;
    tick();
    in_valid = 0; flush = 0;
    chk("flush_in.out_valid", 32'(out_valid), 0);
    in_valid = 1;
    tick();
    in_valid = 0; out_ready = 0;
    tick();
    chk("flush_held.pre_valid", 32'(out_valid), 1);
    flush = 1;
    tick();
    flush = 0;
    chk("flush_held.out_valid", 32'(out_valid), 0);
    out_ready = 1;

    // Reset during a stall discards the held beat.
    in_valid = 1; in_inst = 32'h123452B7; in_pc = 32'h300;
    tick();
    out_ready = 0;
    tick();
    chk("rst_stall.pre_valid", 32'(out_valid), 1);
    rst = 1;
    tick();
    rst = 0; in_valid = 0;
    zero_e = '{default: '0};
    chk("rst_stall.out_valid", 32'(out_valid), 0);
    chk("rst_stall.in_ready", 32'(in_ready), 1);
    check_fields("rst_stall", zero_e);
    out_ready = 1;

    // Random phase: queue model holds at most one beat in flight.
    q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = 1'($urandom_range(1));
      out_ready = ($urandom_range(3) != 0);
      flush     = ($urandom_range(15) == 0);
      in_error  = ($urandom_range(15) == 0);
      in_pc     = $urandom;
      in_inst   = $urandom;
      if ($urandom_range(3) != 0) in_inst[6:0] = ops[$urandom_range(10)];
      if ($urandom_range(1) != 0) in_inst[31:25] = ($urandom_range(1) != 0) ? 7'h20 : 7'h00;
      #2;
      chk("rnd.out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("rnd.in_ready", 32'(in_ready), 32'((q.size() == 0) || out_ready));
      if (q.size() != 0) check_fields("rnd", q[0]);
      acc = in_valid && ((q.size() == 0) || out_ready);
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (flush) q.delete();
      else if (acc) q.push_back(ref_decode(in_inst, in_pc, in_error));
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
